// File: rtl/mt9v034_capture_if.sv
// Bus bundle between the MT9V034 sensor pins and the image DMA side.
//   sen_fv / sen_lv / sen_data : raw sensor frame valid, line valid, 10-bit pixel
//   im_vsync / im_hsync        : frame / line framing towards video2axis
//   im_valid / im_dout         : one-cycle strobe per packed 16-bit pixel pair
// Modports: master drives the sensor side and observes the image side (bench),
//           slave is the capture block.
interface mt9v034_capture_if;
    logic        sen_fv;
    logic        sen_lv;
    logic [9:0]  sen_data;
    logic        im_vsync;
    logic        im_hsync;
    logic        im_valid;
    logic [15:0] im_dout;

    modport master (
        output sen_fv, sen_lv, sen_data,
        input  im_vsync, im_hsync, im_valid, im_dout
    );

    modport slave (
        input  sen_fv, sen_lv, sen_data,
        output im_vsync, im_hsync, im_valid, im_dout
    );
endinterface

// File: rtl/mt9v034_capture.sv
// MT9V034 capture stage: crops a window out of the sensor raster, truncates
// pixels to 8 bits and packs even/odd pixel pairs into 16-bit words.
//   im_pclk    : pixel clock (only clock)
//   rstn       : synchronous reset, active low
//   capture_en : frame gate, looked at only when a frame starts
//   err_clr    : clears the sticky line_err flag
//   bus        : sensor inputs and image outputs (slave modport)
//   frame_cnt  : completed captured frames, wraps
//   line_err   : sticky short-line / short-frame flag
module mt9v034_capture #(
    parameter int H_START = 56,
    parameter int V_START = 0,
    parameter int H_SIZE  = 640,
    parameter int V_SIZE  = 480
) (
    input  logic                    im_pclk,
    input  logic                    rstn,
    input  logic                    capture_en,
    input  logic                    err_clr,
    mt9v034_capture_if.slave        bus,
    output logic [15:0]             frame_cnt,
    output logic                    line_err
);
    localparam logic [3:0] S_WAIT  = 4'b0001;
    localparam logic [3:0] S_IDLE  = 4'b0010;
    localparam logic [3:0] S_FRAME = 4'b0100;
    localparam logic [3:0] S_SKIP  = 4'b1000;

    localparam logic [12:0] H_LO = 13'(H_START);
    localparam logic [12:0] H_HI = 13'(H_START + H_SIZE);
    localparam logic [12:0] V_LO = 13'(V_START);
    localparam logic [12:0] V_HI = 13'(V_START + V_SIZE);

    logic        fv_r, lv_r, fv_rr, lv_rr;
    logic [9:0]  data_r;
    logic [7:0]  data_rr;     // pixel byte aligned with lv_rr / col
    logic [3:0]  state, state_next;
    logic [11:0] col, row;
    logic        phase;
    logic [7:0]  even_byte;

    logic        fv_rise, fv_fall, lv_fall, in_frame, row_in, col_in, pix_win;
    logic        short_line, short_frame;
    logic [12:0] rows_done;
    logic        unused_lsb;

    // The two LSBs are registered with the rest of the bus but dropped by truncation.
    assign unused_lsb = ^data_r[1:0];

    assign fv_rise  = fv_r & ~fv_rr;
    assign fv_fall  = ~fv_r & fv_rr;
    assign lv_fall  = ~lv_r & lv_rr;
    assign in_frame = (state == S_FRAME);
    assign row_in   = ({1'b0, row} >= V_LO) && ({1'b0, row} < V_HI);
    assign col_in   = ({1'b0, col} >= H_LO) && ({1'b0, col} < H_HI);
    assign pix_win  = in_frame & lv_rr & row_in & col_in;

    // col is the index of the last pixel of the line when lv_fall is seen,
    // so the line length is col+1.
    assign short_line = in_frame & lv_fall & row_in & (({1'b0, col} + 13'd1) < H_HI);
    // An FV fall that coincides with an LV fall also closes that line.
    assign rows_done   = {1'b0, row} + {12'd0, lv_fall};
    assign short_frame = in_frame & fv_fall & (rows_done < V_HI);

    always_comb begin
        state_next = state;
        case (state)
            S_WAIT:  if (!fv_r)   state_next = S_IDLE;
            S_IDLE:  if (fv_rise) state_next = capture_en ? S_FRAME : S_SKIP;
            S_FRAME: if (fv_fall) state_next = S_IDLE;
            S_SKIP:  if (fv_fall) state_next = S_IDLE;
            default:              state_next = S_WAIT;
        endcase
    end

    always_ff @(posedge im_pclk) begin
        if (!rstn) begin
            // FV history resets high so a sensor already mid-frame is not
            // mistaken for a fresh FV rise; S_WAIT waits for a real FV low.
            fv_r         <= 1'b1;
            fv_rr        <= 1'b1;
            lv_r         <= 1'b0;
            lv_rr        <= 1'b0;
            data_r       <= '0;
            data_rr      <= '0;
            state        <= S_WAIT;
            col          <= '0;
            row          <= '0;
            phase        <= 1'b0;
            even_byte    <= '0;
            bus.im_vsync <= 1'b1;
            bus.im_hsync <= 1'b0;
            bus.im_valid <= 1'b0;
            bus.im_dout  <= '0;
            frame_cnt    <= '0;
            line_err     <= 1'b0;
        end else begin
            fv_r    <= bus.sen_fv;
            lv_r    <= bus.sen_lv;
            data_r  <= bus.sen_data;
            fv_rr   <= fv_r;
            lv_rr   <= lv_r;
            data_rr <= data_r[9:2];
            state   <= state_next;

            if (lv_rr) col <= (col == 12'hFFF) ? col : col + 12'd1;
            else       col <= '0;

            if (fv_rise)                        row <= '0;
            else if (lv_fall && row != 12'hFFF) row <= row + 12'd1;

            // Phase restarts before every line, so a dangling even byte is dropped.
            if (!lv_rr)       phase <= 1'b0;
            else if (pix_win) phase <= ~phase;

            if (pix_win && !phase) even_byte <= data_rr;

            bus.im_valid <= pix_win & phase;
            if (pix_win && phase) bus.im_dout <= {data_rr, even_byte};

            bus.im_hsync <= in_frame & lv_rr & row_in;
            bus.im_vsync <= ~in_frame;

            if (in_frame && fv_fall) frame_cnt <= frame_cnt + 16'd1;

            if (short_line || short_frame) line_err <= 1'b1;
            else if (err_clr)              line_err <= 1'b0;
        end
    end
endmodule
